// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the two-port memory bus arbiter.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   localparam logic OWN_CPU  = 1'b0;
   localparam logic OWN_LDR  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner picker: a lone requester always wins; on a tie the
// port not served last wins, or the CPU when fixed priority is selected.
module rr_pick2
   import mem_bus_arbiter_pkg::*;
(
   input  logic [1:0] i_req,        // [0] = CPU, [1] = loader
   input  logic       i_last,       // port granted most recently
   input  logic       i_prio_mode,  // 1 = CPU wins every tie
   output logic       o_grant       // winning port index
);

   // tie-break only matters when both ports request
   always_comb begin
      o_grant = OWN_CPU;
      if (i_req == 2'b10)
         o_grant = OWN_LDR;
      else if (i_req == 2'b11)
         o_grant = i_prio_mode ? OWN_CPU : ~i_last;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the CPU port (C_) and the loader port (L_).
// Each transfer is IDLE -> ACCESS -> (WAIT x MEM_LAT-1) -> DONE, with a
// single MEM_EN strobe in ACCESS and a one-cycle ACK to the winner in DONE.
module mem_bus_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int MEM_LAT  = 1,
   parameter int CPU_PRIO = 0
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          C_REQ,
   input  logic          C_RW,
   input  logic [AW-1:0] C_ADDR,
   input  logic [DW-1:0] C_WDATA,
   output logic [DW-1:0] C_RDATA,
   output logic          C_ACK,
   input  logic          L_REQ,
   input  logic          L_RW,
   input  logic [AW-1:0] L_ADDR,
   input  logic [DW-1:0] L_WDATA,
   output logic [DW-1:0] L_RDATA,
   output logic          L_ACK,
   output logic [AW-1:0] ADDR,
   output logic [DW-1:0] D_OUT,
   output logic          RW,
   output logic          MEM_EN,
   input  logic [DW-1:0] D_IN,
   output logic          OWNER
);
   import mem_bus_arbiter_pkg::*;

   // WAIT counter is wide enough to reach MEM_LAT without wrapping
   localparam int             CW        = $clog2(MEM_LAT) + 1;
   localparam logic [CW-1:0]  WAIT_LAST = CW'(MEM_LAT - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_last;
   logic          r_owner;
   logic          r_rw;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_c_rdata;
   logic [DW-1:0] r_l_rdata;
   logic [CW-1:0] r_wcnt;

   logic          w_grant;
   logic          w_prio;
   logic          w_latch;
   logic          w_mem_en;
   logic          w_done;
   logic          w_capture;

   assign w_prio = (CPU_PRIO != 0);

   rr_pick2 u_rr_pick2 (
      .i_req       ({L_REQ, C_REQ}),
      .i_last      (r_last),
      .i_prio_mode (w_prio),
      .o_grant     (w_grant)
   );

   // state register
   always_ff @(posedge CLK) begin
      if (RESET) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // next state plus per-state strobes; read data is captured on the last
   // cycle before DONE, which is ACCESS itself when MEM_LAT is 1
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_mem_en    = 1'b0;
      w_done      = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (C_REQ || L_REQ) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            w_mem_en = 1'b1;
            if (MEM_LAT > 1) begin
               w_state_nxt = ST_WAIT;
            end else begin
               w_state_nxt = ST_DONE;
               w_capture   = (r_rw == RW_READ);
            end
         end
         ST_WAIT: begin
            if (r_wcnt == WAIT_LAST) begin
               w_state_nxt = ST_DONE;
               w_capture   = (r_rw == RW_READ);
            end
         end
         ST_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // grant latches, wait counter and read-data holding registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_last    <= OWN_LDR;
         r_owner   <= OWN_CPU;
         r_rw      <= RW_READ;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_c_rdata <= '0;
         r_l_rdata <= '0;
         r_wcnt    <= '0;
      end else begin
         if (w_latch) begin
            r_owner <= w_grant;
            r_last  <= w_grant;
            r_rw    <= (w_grant == OWN_LDR) ? L_RW    : C_RW;
            r_addr  <= (w_grant == OWN_LDR) ? L_ADDR  : C_ADDR;
            r_wdata <= (w_grant == OWN_LDR) ? L_WDATA : C_WDATA;
         end
         if (r_state == ST_ACCESS)
            r_wcnt <= CW'(1);
         else if (r_state == ST_WAIT)
            r_wcnt <= r_wcnt + 1'b1;
         if (w_capture && (r_owner == OWN_CPU)) r_c_rdata <= D_IN;
         if (w_capture && (r_owner == OWN_LDR)) r_l_rdata <= D_IN;
      end
   end

   assign ADDR    = r_addr;
   assign D_OUT   = r_wdata;
   assign RW      = (r_rw == RW_WRITE);
   assign MEM_EN  = w_mem_en;
   assign OWNER   = r_owner;
   assign C_ACK   = w_done && (r_owner == OWN_CPU);
   assign L_ACK   = w_done && (r_owner == OWN_LDR);
   assign C_RDATA = r_c_rdata;
   assign L_RDATA = r_l_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance A (MEM_LAT=1, round-robin) and
// instance B (MEM_LAT=3, CPU priority) share request inputs; the idle one
// is held in reset. A transaction-level model predicts winner, timing and
// read data for every transfer.
module tb_mem_bus_arbiter;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       rst_a, rst_b;
   logic       C_REQ, C_RW, L_REQ, L_RW;
   logic [7:0] C_ADDR, C_WDATA, L_ADDR, L_WDATA;

   logic [7:0] a_crd, a_lrd, a_addr, a_dout, a_din;
   logic       a_cack, a_lack, a_rw, a_en, a_own;
   logic [7:0] b_crd, b_lrd, b_addr, b_dout, b_din;
   logic       b_cack, b_lack, b_rw, b_en, b_own;

   mem_bus_arbiter #(.AW(8), .DW(8), .MEM_LAT(1), .CPU_PRIO(0)) u_a (
      .CLK(CLK), .RESET(rst_a),
      .C_REQ(C_REQ), .C_RW(C_RW), .C_ADDR(C_ADDR), .C_WDATA(C_WDATA),
      .C_RDATA(a_crd), .C_ACK(a_cack),
      .L_REQ(L_REQ), .L_RW(L_RW), .L_ADDR(L_ADDR), .L_WDATA(L_WDATA),
      .L_RDATA(a_lrd), .L_ACK(a_lack),
      .ADDR(a_addr), .D_OUT(a_dout), .RW(a_rw), .MEM_EN(a_en),
      .D_IN(a_din), .OWNER(a_own)
   );

   mem_bus_arbiter #(.AW(8), .DW(8), .MEM_LAT(3), .CPU_PRIO(1)) u_b (
      .CLK(CLK), .RESET(rst_b),
      .C_REQ(C_REQ), .C_RW(C_RW), .C_ADDR(C_ADDR), .C_WDATA(C_WDATA),
      .C_RDATA(b_crd), .C_ACK(b_cack),
      .L_REQ(L_REQ), .L_RW(L_RW), .L_ADDR(L_ADDR), .L_WDATA(L_WDATA),
      .L_RDATA(b_lrd), .L_ACK(b_lack),
      .ADDR(b_addr), .D_OUT(b_dout), .RW(b_rw), .MEM_EN(b_en),
      .D_IN(b_din), .OWNER(b_own)
   );

   // memories: data is only presented in the exact cycle it is valid
   logic [7:0] mem_a [0:255];
   logic [7:0] mem_b [0:255];
   logic       b_en1, b_en2;

   always @(posedge CLK) begin
      if (a_en && a_rw) mem_a[a_addr] <= a_dout;
      if (b_en && b_rw) mem_b[b_addr] <= b_dout;
      b_en1 <= b_en;
      b_en2 <= b_en1;
   end
   assign a_din = a_en  ? mem_a[a_addr] : 8'hEE;
   assign b_din = b_en2 ? mem_b[b_addr] : 8'hEE;

   // view of the instance under test
   bit         sel;
   logic [7:0] o_crd, o_lrd, o_addr, o_dout;
   logic       o_cack, o_lack, o_rw, o_en, o_own;
   assign o_crd  = sel ? b_crd  : a_crd;
   assign o_lrd  = sel ? b_lrd  : a_lrd;
   assign o_addr = sel ? b_addr : a_addr;
   assign o_dout = sel ? b_dout : a_dout;
   assign o_cack = sel ? b_cack : a_cack;
   assign o_lack = sel ? b_lack : a_lack;
   assign o_rw   = sel ? b_rw   : a_rw;
   assign o_en   = sel ? b_en   : a_en;
   assign o_own  = sel ? b_own  : a_own;

   // reference model state
   int         errors = 0;
   int         checks = 0;
   int         lat;
   bit         prio;
   bit         last_srv, exp_own;
   bit         pend_c, pend_l;
   logic [7:0] ref_mem [0:1][0:255];
   localparam logic [7:0] POOL = 8'h40;

   task automatic mk_c(input bit rw, input logic [7:0] a, input logic [7:0] d);
      C_REQ = 1'b1; C_RW = rw; C_ADDR = a; C_WDATA = d; pend_c = 1'b1;
   endtask

   task automatic mk_l(input bit rw, input logic [7:0] a, input logic [7:0] d);
      L_REQ = 1'b1; L_RW = rw; L_ADDR = a; L_WDATA = d; pend_l = 1'b1;
   endtask

   // one transfer, entered at the falling edge of an IDLE cycle with the
   // requests already on the inputs; returns at the falling edge of DONE
   task automatic run_xfer(input bit scramble);
      bit         w, wrw;
      logic [7:0] wa, wd, exp_rd;
      logic [1:0] exp_ack;
      checks++;
      if ({o_en, o_cack, o_lack, o_own} !== {3'b000, exp_own}) begin
         errors++;
         $display("FAIL idle got en=%b cack=%b lack=%b own=%b exp 0 0 0 %b",
                  o_en, o_cack, o_lack, o_own, exp_own);
      end
      if (pend_c && pend_l) w = prio ? 1'b0 : ~last_srv;
      else                  w = pend_l;
      wa  = w ? L_ADDR  : C_ADDR;
      wd  = w ? L_WDATA : C_WDATA;
      wrw = w ? L_RW    : C_RW;
      last_srv = w;
      exp_own  = w;
      exp_rd   = ref_mem[sel][wa];
      if (wrw) ref_mem[sel][wa] = wd;
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge CLK);
         checks++;
         if ({o_en, o_addr, o_rw, o_own} !== {(k == 1), wa, wrw, w}) begin
            errors++;
            $display("FAIL bus cyc%0d got en=%b addr=%h rw=%b own=%b exp en=%b addr=%h rw=%b own=%b",
                     k, o_en, o_addr, o_rw, o_own, (k == 1), wa, wrw, w);
         end
         if (k == 1 && wrw) begin
            checks++;
            if (o_dout !== wd) begin
               errors++;
               $display("FAIL dout got %h exp %h", o_dout, wd);
            end
         end
         exp_ack = (k == lat + 1) ? (w ? 2'b01 : 2'b10) : 2'b00;
         checks++;
         if ({o_cack, o_lack} !== exp_ack) begin
            errors++;
            $display("FAIL ack cyc%0d got c=%b l=%b exp %b", k, o_cack, o_lack, exp_ack);
         end
         if (k == lat + 1 && !wrw) begin
            checks++;
            if ((w ? o_lrd : o_crd) !== exp_rd) begin
               errors++;
               $display("FAIL rdata port=%0d addr=%h got %h exp %h",
                        w, wa, (w ? o_lrd : o_crd), exp_rd);
            end
         end
         if (k == 1 && scramble) begin
            if (w) begin
               L_ADDR = 8'($urandom); L_WDATA = 8'($urandom); L_RW = ~L_RW;
               L_REQ  = 1'($urandom_range(0, 1));
            end else begin
               C_ADDR = 8'($urandom); C_WDATA = 8'($urandom); C_RW = ~C_RW;
               C_REQ  = 1'($urandom_range(0, 1));
            end
         end
         if (k == lat + 1) begin
            if (w) begin L_REQ = 1'b0; pend_l = 1'b0; end
            else   begin C_REQ = 1'b0; pend_c = 1'b0; end
         end
      end
   endtask

   task automatic select_cfg(input bit s);
      sel = s; lat = s ? 3 : 1; prio = s;
      rst_a = 1'b1; rst_b = 1'b1;
      C_REQ = 1'b0; L_REQ = 1'b0; pend_c = 1'b0; pend_l = 1'b0;
      repeat (2) @(negedge CLK);
      if (s) rst_b = 1'b0; else rst_a = 1'b0;
      last_srv = 1'b1; exp_own = 1'b0;
   endtask

   task automatic test_reset;
      sel = 1'b0; lat = 1; prio = 1'b0;
      rst_a = 1'b1; rst_b = 1'b1;
      pend_c = 1'b0; pend_l = 1'b0;
      mk_c(1'b1, 8'h30, 8'hC3);
      mk_l(1'b1, 8'h31, 8'h3C);
      repeat (3) begin
         @(negedge CLK);
         checks++;
         if ({o_en, o_cack, o_lack, o_addr, o_own, o_crd, o_lrd, o_rw, o_dout} !== '0) begin
            errors++;
            $display("FAIL reset got en=%b cack=%b lack=%b addr=%h own=%b crd=%h lrd=%h rw=%b dout=%h exp all 0",
                     o_en, o_cack, o_lack, o_addr, o_own, o_crd, o_lrd, o_rw, o_dout);
         end
      end
      rst_a = 1'b0; last_srv = 1'b1; exp_own = 1'b0;
      run_xfer(1'b0);              // tie after reset: CPU
      @(negedge CLK);
      run_xfer(1'b0);              // loader still pending
   endtask

   task automatic test_cpu_rw;
      @(negedge CLK); mk_c(1'b1, 8'h10, 8'h5A); run_xfer(1'b0);
      @(negedge CLK); mk_c(1'b0, 8'h10, 8'h00); run_xfer(1'b0);
      checks++;
      if (o_crd !== 8'h5A) begin
         errors++;
         $display("FAIL cpu_readback got %h exp 5a", o_crd);
      end
   endtask

   task automatic test_both_held(input int n);
      repeat (n) begin
         @(negedge CLK);
         if (!pend_c) mk_c(1'($urandom_range(0, 1)), POOL + 8'($urandom_range(0, 7)), 8'($urandom));
         if (!pend_l) mk_l(1'($urandom_range(0, 1)), POOL + 8'($urandom_range(0, 7)), 8'($urandom));
         run_xfer(1'b0);
      end
      while (pend_c || pend_l) begin
         @(negedge CLK);
         run_xfer(1'b0);
      end
   endtask

   task automatic prewrite;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         mk_c(1'b1, POOL + 8'(i), 8'($urandom));
         run_xfer(1'b0);
      end
   endtask

   task automatic test_random(input int n);
      repeat (n) begin
         @(negedge CLK);
         if (!pend_c && $urandom_range(0, 1) == 1)
            mk_c(1'($urandom_range(0, 1)), POOL + 8'($urandom_range(0, 7)), 8'($urandom));
         if (!pend_l && $urandom_range(0, 1) == 1)
            mk_l(1'($urandom_range(0, 1)), POOL + 8'($urandom_range(0, 7)), 8'($urandom));
         if (!pend_c && !pend_l)
            mk_l(1'($urandom_range(0, 1)), POOL + 8'($urandom_range(0, 7)), 8'($urandom));
         run_xfer(1'b1);
      end
      while (pend_c || pend_l) begin
         @(negedge CLK);
         run_xfer(1'b0);
      end
   endtask

   task automatic test_ldr_wait;
      @(negedge CLK); mk_l(1'b1, 8'h20, 8'h77); run_xfer(1'b0);
      @(negedge CLK); mk_l(1'b0, 8'h20, 8'h00); run_xfer(1'b0);
      checks++;
      if (o_lrd !== 8'h77) begin
         errors++;
         $display("FAIL ldr_readback got %h exp 77", o_lrd);
      end
   endtask

   task automatic test_reset_wait;
      @(negedge CLK); mk_c(1'b0, 8'h20, 8'h00);   // IDLE, request presented
      @(negedge CLK);                               // ACCESS
      checks++;
      if (o_en !== 1'b1) begin
         errors++;
         $display("FAIL rw_access got en=%b exp 1", o_en);
      end
      @(negedge CLK);                               // first WAIT
      checks++;
      if ({o_en, o_cack, o_addr} !== {2'b00, 8'h20}) begin
         errors++;
         $display("FAIL rw_wait got en=%b cack=%b addr=%h exp 0 0 20", o_en, o_cack, o_addr);
      end
      rst_b = 1'b1;
      @(negedge CLK);
      checks++;
      if ({o_en, o_cack, o_lack, o_addr, o_own, o_crd, o_rw} !== '0) begin
         errors++;
         $display("FAIL rw_reset got en=%b cack=%b lack=%b addr=%h own=%b crd=%h rw=%b exp all 0",
                  o_en, o_cack, o_lack, o_addr, o_own, o_crd, o_rw);
      end
      rst_b = 1'b0; last_srv = 1'b1; exp_own = 1'b0;
      run_xfer(1'b0);                               // request still held
      checks++;
      if (o_crd !== 8'h77) begin
         errors++;
         $display("FAIL rw_after got %h exp 77", o_crd);
      end
   endtask

   initial begin
      C_REQ = 1'b0; C_RW = 1'b0; C_ADDR = '0; C_WDATA = '0;
      L_REQ = 1'b0; L_RW = 1'b0; L_ADDR = '0; L_WDATA = '0;
      rst_a = 1'b1; rst_b = 1'b1;
      test_reset;
      test_cpu_rw;
      prewrite;
      test_both_held(6);
      test_random(40);
      select_cfg(1'b1);
      test_ldr_wait;
      test_both_held(4);
      test_reset_wait;
      prewrite;
      test_random(30);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
